// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU lw/sw port and loader/DMA port share one synchronous-read memory.
// CPU has priority; a starvation counter forces a loader win after STARVE denied cycles.
module dmem_arbiter #(
   parameter int AW     = 11,
   parameter int DW     = 32,
   parameter int STARVE = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [31:0]   c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_stall,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   // state | meaning
   // IDLE  | no read outstanding
   // CRD   | CPU read data returns this cycle
   // LRD   | loader read data returns this cycle
   typedef enum logic [1:0] {IDLE, CRD, LRD} state_t;

   localparam int SW = $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_starve_cnt;
   logic          r_m_we;
   logic [AW-1:0] r_m_addr;
   logic [DW-1:0] r_m_wdata;
   logic [DW-1:0] r_c_rdata;
   logic [DW-1:0] r_l_rdata;

   logic          w_c_req;
   logic          w_l_req;
   logic          w_c_win;
   logic          w_l_win;
   logic [AW-1:0] w_c_addr;
   logic          w_unused;

   assign w_c_addr = c_addr[AW+1:2];
   assign w_unused = ^{c_addr[31:AW+2], c_addr[1:0]};

   // CPU request in CRD belongs to the load now completing, so it is masked
   assign w_c_req = rst & c_req & (r_state != CRD);
   assign w_l_req = rst & l_req;
   assign w_c_win = w_c_req & ~(w_l_req & (r_starve_cnt == STARVE_C));
   assign w_l_win = w_l_req & ~w_c_win;

   always_comb begin
      m_en    = w_c_win | w_l_win;
      l_gnt   = w_l_win;
      c_stall = w_c_req & ~(w_c_win & c_we);
      m_we    = r_m_we;
      m_addr  = r_m_addr;
      m_wdata = r_m_wdata;
      w_next  = IDLE;
      if (w_c_win) begin
         m_we    = c_we;
         m_addr  = w_c_addr;
         m_wdata = c_wdata;
         if (!c_we) w_next = CRD;
      end else if (w_l_win) begin
         m_we    = l_we;
         m_addr  = l_addr;
         m_wdata = l_wdata;
         if (!l_we) w_next = LRD;
      end
   end

   assign c_rdata  = (r_state == CRD) ? m_rdata : r_c_rdata;
   assign l_rvalid = (r_state == LRD);
   assign l_rdata  = (r_state == LRD) ? m_rdata : r_l_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_m_we       <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_c_rdata    <= '0;
         r_l_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (!l_req || w_l_win)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_C)
            r_starve_cnt <= r_starve_cnt + 1'b1;
         if (m_en) begin
            r_m_we    <= m_we;
            r_m_addr  <= m_addr;
            r_m_wdata <= m_wdata;
         end
         if (r_state == CRD) r_c_rdata <= m_rdata;
         if (r_state == LRD) r_l_rdata <= m_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for single-cycle behaviour, directed sequences for
// starvation and reset during a read. Includes a synchronous-read memory model.
module tb_dmem_arbiter;
   localparam int AW = 11;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we;
   logic [31:0]   c_addr;
   logic [DW-1:0] c_wdata, c_rdata;
   logic          c_stall;
   logic          l_req, l_we;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic          l_gnt, l_rvalid;
   logic [DW-1:0] l_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      m_rdata     <= mem[m_addr];
      end
   end

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE(8)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_stall(c_stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   typedef struct {
      logic          c_req;
      logic          c_we;
      logic [31:0]   c_addr;
      logic [31:0]   c_wdata;
      logic          l_req;
      logic          l_we;
      logic [10:0]   l_addr;
      logic [31:0]   l_wdata;
      logic          e_stall;
      logic          e_gnt;
      logic          e_en;
      logic          e_we;
      logic [10:0]   e_addr;
      logic [31:0]   e_wdata;
      logic          e_lrv;
      logic [31:0]   e_ldata;
      logic [31:0]   e_cdata;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic lr, input logic lw, input logic [10:0] la, input logic [31:0] ld);
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
   endtask

   task automatic apply(input vec_t v, input int idx);
      string s;
      drive(v.c_req, v.c_we, v.c_addr, v.c_wdata, v.l_req, v.l_we, v.l_addr, v.l_wdata);
      @(negedge clk);
      s = $sformatf("v%0d", idx);
      chk({s, ".c_stall"}, 32'(c_stall), 32'(v.e_stall));
      chk({s, ".l_gnt"},   32'(l_gnt),   32'(v.e_gnt));
      chk({s, ".m_en"},    32'(m_en),    32'(v.e_en));
      chk({s, ".l_rvalid"}, 32'(l_rvalid), 32'(v.e_lrv));
      chk({s, ".c_rdata"}, c_rdata, v.e_cdata);
      if (v.e_en) begin
         chk({s, ".m_we"},   32'(m_we),   32'(v.e_we));
         chk({s, ".m_addr"}, 32'(m_addr), 32'(v.e_addr));
         if (v.e_we) chk({s, ".m_wdata"}, m_wdata, v.e_wdata);
      end
      if (v.e_lrv) chk({s, ".l_rdata"}, l_rdata, v.e_ldata);
      @(posedge clk); #1;
   endtask

   initial begin
      //       c_req c_we c_addr        c_wdata       l_req l_we l_addr l_wdata   stall gnt en we addr  wdata        lrv ldata   cdata
      vt.push_back('{1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 11'd0, 32'h0,       0, 0, 1, 1, 11'd4, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vt.push_back('{1, 0, 32'h10,       32'h0,        0, 0, 11'd0, 32'h0,       1, 0, 1, 0, 11'd4, 32'h0,        0, 32'h0,  32'h0});
      vt.push_back('{1, 0, 32'h10,       32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        0, 32'h0,  32'hDEADBEEF});
      vt.push_back('{0, 0, 32'h0,        32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        0, 32'h0,  32'hDEADBEEF});
      for (int i = 0; i < 4; i++)
         vt.push_back('{0, 0, 32'h0, 32'h0, 1, 1, 11'(i), 32'hA0 + 32'(i),
                        0, 1, 1, 1, 11'(i), 32'hA0 + 32'(i), 0, 32'h0, 32'hDEADBEEF});
      for (int i = 0; i < 4; i++)
         vt.push_back('{0, 0, 32'h0, 32'h0, 1, 0, 11'(i), 32'h0,
                        0, 1, 1, 0, 11'(i), 32'h0, (i > 0), 32'hA0 + 32'(i) - 32'd1, 32'hDEADBEEF});
      vt.push_back('{0, 0, 32'h0,        32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        1, 32'hA3, 32'hDEADBEEF});
      // CPU load of word 2 (ignored high and low address bits) racing a loader read of word 3
      vt.push_back('{1, 0, 32'hABCD000B, 32'h0,        1, 0, 11'd3, 32'h0,       1, 0, 1, 0, 11'd2, 32'h0,        0, 32'h0,  32'hDEADBEEF});
      vt.push_back('{1, 0, 32'hABCD000B, 32'h0,        1, 0, 11'd3, 32'h0,       0, 1, 1, 0, 11'd3, 32'h0,        0, 32'h0,  32'hA2});
      vt.push_back('{0, 0, 32'h0,        32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        1, 32'hA3, 32'hA2});
      vt.push_back('{1, 1, 32'h14,       32'h55,       1, 1, 11'd7, 32'h77,      0, 0, 1, 1, 11'd5, 32'h55,       0, 32'h0,  32'hA2});
      vt.push_back('{0, 0, 32'h0,        32'h0,        1, 1, 11'd7, 32'h77,      0, 1, 1, 1, 11'd7, 32'h77,       0, 32'h0,  32'hA2});
      vt.push_back('{1, 0, 32'h14,       32'h0,        0, 0, 11'd0, 32'h0,       1, 0, 1, 0, 11'd5, 32'h0,        0, 32'h0,  32'hA2});
      vt.push_back('{1, 0, 32'h14,       32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        0, 32'h0,  32'h55});
      vt.push_back('{1, 0, 32'h1C,       32'h0,        0, 0, 11'd0, 32'h0,       1, 0, 1, 0, 11'd7, 32'h0,        0, 32'h0,  32'h55});
      vt.push_back('{1, 0, 32'h1C,       32'h0,        0, 0, 11'd0, 32'h0,       0, 0, 0, 0, 11'd0, 32'h0,        0, 32'h0,  32'h77});

      // requests asserted during reset must not reach the memory
      rst = 1'b0;
      drive(1, 0, 32'h10, 32'h0, 1, 0, 11'd1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.c_stall",  32'(c_stall),  32'h0);
      chk("rst.l_gnt",    32'(l_gnt),    32'h0);
      chk("rst.m_en",     32'(m_en),     32'h0);
      chk("rst.m_we",     32'(m_we),     32'h0);
      chk("rst.l_rvalid", 32'(l_rvalid), 32'h0);
      chk("rst.c_rdata",  c_rdata,       32'h0);
      chk("rst.l_rdata",  l_rdata,       32'h0);
      drive(0, 0, 32'h0, 32'h0, 0, 0, 11'd0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (vt[i]) apply(vt[i], i);

      // starvation: CPU writes every cycle; loader denied 8 cycles then wins; repeated to show the count cleared
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 9; k++) begin
            drive(1, 1, 32'h100 + 32'(4*k), 32'h1000 + 32'(k), 1, 1, 11'd6, 32'h66 + 32'(r));
            @(negedge clk);
            if (k < 8) begin
               chk($sformatf("starve%0d.deny%0d.l_gnt", r, k), 32'(l_gnt), 32'h0);
               chk($sformatf("starve%0d.deny%0d.c_stall", r, k), 32'(c_stall), 32'h0);
            end else begin
               chk($sformatf("starve%0d.win.l_gnt", r), 32'(l_gnt), 32'h1);
               chk($sformatf("starve%0d.win.c_stall", r), 32'(c_stall), 32'h1);
               chk($sformatf("starve%0d.win.m_addr", r), 32'(m_addr), 32'd6);
               chk($sformatf("starve%0d.win.m_wdata", r), m_wdata, 32'h66 + 32'(r));
            end
            @(posedge clk); #1;
         end
         drive(1, 1, 32'h120, 32'h2000, 0, 0, 11'd0, 32'h0);
         @(negedge clk);
         chk($sformatf("starve%0d.retry.c_stall", r), 32'(c_stall), 32'h0);
         chk($sformatf("starve%0d.retry.m_addr", r), 32'(m_addr), 32'd72);
         @(posedge clk); #1;
      end

      // reset asserted in the CRD cycle drops the read
      drive(1, 0, 32'h18, 32'h0, 1, 0, 11'd0, 32'h0);
      @(negedge clk);
      chk("rstrd.issue.c_stall", 32'(c_stall), 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rstrd.c_stall",  32'(c_stall),  32'h0);
      chk("rstrd.l_rvalid", 32'(l_rvalid), 32'h0);
      chk("rstrd.m_en",     32'(m_en),     32'h0);
      chk("rstrd.l_gnt",    32'(l_gnt),    32'h0);
      chk("rstrd.c_rdata",  c_rdata,       32'h0);
      drive(0, 0, 32'h0, 32'h0, 0, 0, 11'd0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1, 0, 32'h18, 32'h0, 0, 0, 11'd0, 32'h0);
      @(negedge clk);
      chk("post.idle.c_stall", 32'(c_stall), 32'h1);
      chk("post.idle.m_en",    32'(m_en),    32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post.crd.c_stall", 32'(c_stall), 32'h0);
      chk("post.crd.c_rdata", c_rdata,      32'h67);
      @(posedge clk); #1;
      drive(0, 0, 32'h0, 32'h0, 0, 0, 11'd0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

The data-memory arbiter shares one single-port, synchronous-read data memory between two requesters: the single-cycle CPU data port (lw/sw) and a loader/DMA port used for program loading and debug readback. The CPU keeps priority, and a starvation counter guarantees the loader makes progress. The arbiter stalls the CPU while its access is pending. It sits between the CPU's DM port and the data memory macro.

## Interface
- AW, 11, word-address width of the data memory (2^AW words)
- DW, 32, data width
- STARVE, 8, number of consecutive denied loader cycles after which the loader wins the next contention

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  CPU data access this cycle (DM_ena)
- c_we  in  1  CPU write (DM_w); 0 = read
- c_addr  in  32  CPU byte address; word index = c_addr[AW+1:2]; other bits ignored
- c_wdata  in  DW  CPU store data
- c_rdata  out  DW  CPU load data, valid when the read completes
- c_stall  out  1  hold the CPU (PC and register-file write) this cycle
- l_req  in  1  loader access request, held until granted
- l_we  in  1  loader write
- l_addr  in  AW  loader word address
- l_wdata  in  DW  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DW  loader read data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write
- m_addr  out  AW  memory word address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid the cycle after a read strobe

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - CRD: a CPU read returns this cycle.
  - LRD: a loader read returns this cycle.
- Winner selection in IDLE and LRD:
  - CPU wins if c_req and not (l_req and starve_cnt==STARVE).
  - Otherwise the loader wins if l_req.
  - The memory carries at most one issue per cycle.
- CPU write win: m_en=1, m_we=1, c_stall=0. The write completes this cycle. Next state IDLE.
- CPU read win: m_en=1, m_we=0, c_stall=1. Next state CRD.
- CPU request pending but not won: c_stall=1. No memory access for the CPU.
- Loader win: l_gnt=1 combinationally and the memory driven from the l_* inputs. A read goes to LRD; a write goes to IDLE.
- CRD:
  - c_rdata=m_rdata and c_stall=0.
  - c_req is masked because it belongs to the instruction now completing.
  - The loader may be granted this cycle; the next state follows the loader issue, or IDLE if none.
- LRD: l_rvalid=1 and l_rdata=m_rdata. Arbitration runs concurrently as in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE) on each cycle with l_req=1 and l_gnt=0.
  - Clears on l_gnt or l_req=0.
- When m_en=0, m_we, m_addr and m_wdata hold their previous values. c_rdata holds its last value outside CRD.

## Timing
- Reset (rst=0, asynchronous, including mid-read) forces:
  - state IDLE, starve_cnt 0, l_rvalid 0, l_rdata 0, c_rdata 0.
  - m_en, m_we, l_gnt and c_stall all 0 while rst is low.
- A read in flight when reset asserts is dropped.
- Latency:
  - CPU write: 0 stall cycles.
  - CPU read: exactly 1 stall cycle when uncontended.
  - Loader write: completes in the grant cycle.
  - Loader read: l_rvalid one cycle after l_gnt.
- Back-to-back: loader reads may issue every cycle (LRD to LRD). A CPU read followed by a CPU access needs CRD, so a CPU read occupies 2 cycles.
- Simultaneous requests: the CPU wins unless the starve threshold is reached. When the loader wins by starvation, the CPU stalls exactly that one cycle and starve_cnt clears.
- The loader must hold l_req, l_we, l_addr and l_wdata stable until l_gnt.
- No address check: all c_addr high bits and c_addr[1:0] are ignored.

## Test plan
- Reset mid-read: issue a CPU read, then assert rst=0 in the CRD cycle. Required: c_stall=0, l_rvalid=0 and m_en=0 immediately; state IDLE after release.
- CPU sw alone with c_addr=0x10 and c_wdata=0xDEADBEEF. Required in the same cycle: m_en=1, m_we=1, m_addr=4, m_wdata=0xDEADBEEF, c_stall=0.
- CPU lw from c_addr=0x10 after the previous store. Required:
  - cycle 0: c_stall=1, m_en=1, m_we=0.
  - cycle 1: c_stall=0, c_rdata=0xDEADBEEF.
- Starvation with STARVE=8: l_req held and the CPU issues a write every cycle. Required:
  - the loader is denied 8 cycles;
  - on the 9th cycle l_gnt=1, c_stall=1 and m_addr=l_addr;
  - starve_cnt returns to 0.
- Loader burst: write words 0..3 with values 0xA0..0xA3, then read words 0..3 back-to-back. Required: l_gnt=1 every cycle, and l_rvalid=1 on the 4 following cycles with l_rdata 0xA0, 0xA1, 0xA2, 0xA3 in order.
- CPU read with the loader pending: c_req lw and l_req read both asserted. Required:
  - cycle 0: CPU issues.
  - cycle 1 (CRD): c_rdata valid, c_stall=0, l_gnt=1.
  - cycle 2: l_rvalid=1 with the correct data.
